// File: rtl/fpu_bus_if.sv
// Byte-wide CPU bus front end for the fpu core: operand/op registers, command FSM,
// timeout supervision and result capture. Optional interrupt enabled by FPU_BUS_IRQ_EN.
module fpu_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned OP_W           = 4
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            cs,
    input  logic            wr,
    input  logic            rd,
    input  logic [3:0]      addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            irq,
    output logic            fpu_start,
    output logic [31:0]     fpu_a_operand,
    output logic [31:0]     fpu_b_operand,
    output logic [OP_W-1:0] fpu_operation,
    input  logic [31:0]     fpu_result,
    input  logic            fpu_cmd_end,
    input  logic            fpu_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [OP_W-1:0]   op_reg;
    logic [31:0]       result_reg;
    logic              done;
    logic              err_timeout;
    logic              err_wr_busy;
    logic              done_nxt;
    logic              err_timeout_nxt;
    logic              err_wr_busy_nxt;
    logic              status_irq;
    logic [7:0]        status;
    logic [7:0]        rd_mux;

    logic wr_en;
    logic rd_en;
    logic ctrl_wr;
    logic go_wr;
    logic clr_wr;
    logic reg_wr;
    logic busy;
    logic go_accept;
    logic wr_reject;
    logic timeout_hit;

    assign wr_en       = cs & wr;
    assign rd_en       = cs & rd;
    assign ctrl_wr     = wr_en && (addr == 4'h9);
    assign go_wr       = ctrl_wr && wdata[0];
    assign clr_wr      = ctrl_wr && wdata[1];
    assign reg_wr      = wr_en && (addr <= 4'h8);
    assign busy        = (state != IDLE);
    assign go_accept   = go_wr && !busy && !fpu_busy;
    assign wr_reject   = (reg_wr && busy) || (go_wr && (busy || fpu_busy));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    assign fpu_a_operand = a_reg;
    assign fpu_b_operand = b_reg;
    assign fpu_operation = op_reg;

    always_comb begin
        state_nxt = state;
        fpu_start = 1'b0;
        case (state)
            IDLE:    if (go_accept) state_nxt = ISSUE;
            ISSUE: begin
                fpu_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                fpu_start = 1'b1;
                if (fpu_cmd_end || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clears (CLR or accepted GO) apply first so later sets in the same cycle win.
    always_comb begin
        done_nxt        = done;
        err_timeout_nxt = err_timeout;
        err_wr_busy_nxt = err_wr_busy;
        if (clr_wr || go_accept) begin
            done_nxt        = 1'b0;
            err_timeout_nxt = 1'b0;
            err_wr_busy_nxt = 1'b0;
        end
        if (wr_reject) err_wr_busy_nxt = 1'b1;
        if ((state == WAIT) && !fpu_cmd_end && timeout_hit) err_timeout_nxt = 1'b1;
        if (state == DONE) done_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            result_reg  <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_wr_busy <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= done_nxt;
            err_timeout <= err_timeout_nxt;
            err_wr_busy <= err_wr_busy_nxt;
            wait_cnt    <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (reg_wr && !busy) begin
                case (addr)
                    4'h0, 4'h1, 4'h2, 4'h3: a_reg[{addr[1:0], 3'b000} +: 8] <= wdata;
                    4'h4, 4'h5, 4'h6, 4'h7: b_reg[{addr[1:0], 3'b000} +: 8] <= wdata;
                    default:                op_reg <= wdata[OP_W-1:0];
                endcase
            end
            if ((state == WAIT) && fpu_cmd_end) result_reg <= fpu_result;
        end
    end

`ifdef FPU_BUS_IRQ_EN
    logic irq_pend;
    logic ien;
    logic irq_pend_nxt;
    logic ien_nxt;

    // irq is registered from next-state values so it rises on the edge leaving DONE.
    always_comb begin
        irq_pend_nxt = irq_pend;
        ien_nxt      = ctrl_wr ? wdata[2] : ien;
        if (clr_wr) irq_pend_nxt = 1'b0;
        if (state == DONE) irq_pend_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            irq_pend <= 1'b0;
            ien      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq_pend <= irq_pend_nxt;
            ien      <= ien_nxt;
            irq      <= irq_pend_nxt & ien_nxt;
        end
    end

    assign status_irq = irq_pend;
`else
    assign irq        = 1'b0;
    assign status_irq = 1'b0;
`endif

    assign status = {3'b000, status_irq, err_wr_busy, err_timeout, done, busy};

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            4'h0:    rd_mux = a_reg[7:0];
            4'h1:    rd_mux = a_reg[15:8];
            4'h2:    rd_mux = a_reg[23:16];
            4'h3:    rd_mux = a_reg[31:24];
            4'h4:    rd_mux = b_reg[7:0];
            4'h5:    rd_mux = b_reg[15:8];
            4'h6:    rd_mux = b_reg[23:16];
            4'h7:    rd_mux = b_reg[31:24];
            4'h8:    rd_mux = 8'(op_reg);
            4'hA:    rd_mux = status;
            4'hC:    rd_mux = result_reg[7:0];
            4'hD:    rd_mux = result_reg[15:8];
            4'hE:    rd_mux = result_reg[23:16];
            4'hF:    rd_mux = result_reg[31:24];
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            rdata <= 8'h00;
        end else if (rd_en) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_fpu_bus_if.sv
// Self-checking bench for fpu_bus_if with a mock fpu core and a result scoreboard.
// Build with FPU_BUS_IRQ_EN defined to exercise the interrupt path.
module tb_fpu_bus_if;

    localparam logic [3:0] OP_ADD = 4'd1;

    logic        clk = 1'b0;
    logic        arst;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        irq;
    logic        fpu_start;
    logic [31:0] fpu_a_operand;
    logic [31:0] fpu_b_operand;
    logic [3:0]  fpu_operation;
    logic [31:0] fpu_result;
    logic        fpu_cmd_end = 1'b0;
    logic        fpu_busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    int          mock_delay   = 5;
    bit          mock_respond = 1'b1;
    logic [31:0] mock_result  = 32'h0;
    int          issue_count  = 0;
    int          start_cycles = 0;
    int          mock_cyc     = 0;
    bit          mock_active  = 1'b0;

    fpu_bus_if #(.TIMEOUT_CYCLES(16), .OP_W(4)) dut (
        .clk           (clk),
        .arst          (arst),
        .cs            (cs),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .irq           (irq),
        .fpu_start     (fpu_start),
        .fpu_a_operand (fpu_a_operand),
        .fpu_b_operand (fpu_b_operand),
        .fpu_operation (fpu_operation),
        .fpu_result    (fpu_result),
        .fpu_cmd_end   (fpu_cmd_end),
        .fpu_busy      (fpu_busy)
    );

    always #5 clk = ~clk;

    assign fpu_result = mock_result;

    // Mock core: pulses cmd_end on the mock_delay-th cycle of a start assertion.
    always @(negedge clk) begin
        fpu_cmd_end = 1'b0;
        if (fpu_start && !mock_active) begin
            mock_active  = 1'b1;
            mock_cyc     = 1;
            start_cycles = 1;
            issue_count++;
        end else if (fpu_start) begin
            mock_cyc++;
            start_cycles++;
        end else begin
            mock_active = 1'b0;
        end
        if (fpu_start && mock_respond && (mock_cyc == mock_delay)) fpu_cmd_end = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                 input logic [7:0] ctrl, input bit push, input logic [31:0] expected);
        for (int i = 0; i < 4; i++) busWrite(4'(i), a[8*i +: 8]);
        for (int i = 0; i < 4; i++) busWrite(4'(4 + i), b[8*i +: 8]);
        busWrite(4'h8, {4'h0, op});
        if (push) exp_q.push_back(expected);
        busWrite(4'h9, ctrl);
    endtask

    task automatic waitDone(input string tag, output logic [7:0] st);
        st = 8'h00;
        for (int i = 0; i < 100; i++) begin
            busRead(4'hA, st);
            if (st[1]) break;
        end
        checkOutput({tag, "_done"}, 32'(st[1]), 32'd1);
    endtask

    task automatic checkResult(input string tag);
        logic [7:0]  b;
        logic [31:0] r;
        logic [31:0] e;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            busRead(4'(12 + i), b);
            r[8*i +: 8] = b;
        end
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput(tag, r, e);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  st;
        logic [7:0]  acc;
        logic [7:0]  b;
        int          issue_before;

        arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; wdata = 8'h00; fpu_busy = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;

        checkOutput("reset_rdata", 32'(rdata), 32'h0);
        checkOutput("reset_start", 32'(fpu_start), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        busRead(4'hA, st);
        checkOutput("reset_status", 32'(st), 32'h0);

        // Normal add: 1.0 + 1.1
        mock_delay = 5; mock_result = 32'h40066666;
        applyStimulus(32'h3f800000, 32'h3f8ccccd, OP_ADD, 8'h01, 1'b1, 32'h40066666);
        checkOutput("add_start_issue", 32'(fpu_start), 32'h1);
        checkOutput("add_a_operand", fpu_a_operand, 32'h3f800000);
        checkOutput("add_b_operand", fpu_b_operand, 32'h3f8ccccd);
        checkOutput("add_operation", 32'(fpu_operation), 32'(OP_ADD));
        waitDone("add", st);
        checkOutput("add_status", 32'(st), 32'h02);
        checkOutput("add_start_cycles", 32'(start_cycles), 32'd5);
        checkResult("add_result");

        // Back-to-back commands; second GO combined with CLR
        mock_result = 32'h42400000;
        applyStimulus(32'h41800000, 32'h42000000, OP_ADD, 8'h01, 1'b1, 32'h42400000);
        waitDone("b2b1", st);
        checkResult("b2b1_result");
        mock_result = 32'h3f400000;
        applyStimulus(32'h3e800000, 32'h3f000000, OP_ADD, 8'h03, 1'b1, 32'h3f400000);
        busRead(4'hA, st);
        checkOutput("b2b2_done_cleared", 32'(st), 32'h01);
        waitDone("b2b2", st);
        checkOutput("b2b2_status", 32'(st), 32'h02);
        checkResult("b2b2_result");

        // Writes while busy are dropped
        mock_delay = 12; mock_result = 32'h40400000;
        issue_before = issue_count;
        applyStimulus(32'h3f800000, 32'h40000000, OP_ADD, 8'h01, 1'b1, 32'h40400000);
        busWrite(4'h0, 8'hFF);
        busWrite(4'h9, 8'h01);
        checkOutput("busy_a_unchanged", fpu_a_operand, 32'h3f800000);
        waitDone("busy", st);
        checkOutput("busy_status", 32'(st), 32'h0A);
        checkOutput("busy_issue_count", 32'(issue_count - issue_before), 32'd1);
        checkResult("busy_result");

        // GO rejected while core reports busy
        busWrite(4'h9, 8'h02);
        issue_before = issue_count;
        fpu_busy = 1'b1;
        busWrite(4'h9, 8'h01);
        fpu_busy = 1'b0;
        busRead(4'hA, st);
        checkOutput("fpubusy_status", 32'(st), 32'h08);
        checkOutput("fpubusy_no_issue", 32'(issue_count - issue_before), 32'd0);

        // Timeout: core never answers, result keeps its old value
        mock_respond = 1'b0; mock_result = 32'hDEADBEEF;
        applyStimulus(32'h3f800000, 32'h3f800000, OP_ADD, 8'h01, 1'b1, 32'h40400000);
        waitDone("timeout", st);
        checkOutput("timeout_status", 32'(st), 32'h06);
        checkOutput("timeout_start_cycles", 32'(start_cycles), 32'd17);
        checkResult("timeout_result");

        // Reset in the middle of WAIT
        applyStimulus(32'h11223344, 32'h55667788, OP_ADD, 8'h01, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        checkOutput("rst_start", 32'(fpu_start), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_a_operand", fpu_a_operand, 32'h0);
        busRead(4'hA, st);
        checkOutput("rst_status", 32'(st), 32'h00);
        acc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            busRead(4'(i), b);
            acc = acc | b;
        end
        checkOutput("rst_all_reads", 32'(acc), 32'h0);
        mock_respond = 1'b1; mock_delay = 3; mock_result = 32'h40800000;
        applyStimulus(32'h40000000, 32'h40000000, OP_ADD, 8'h01, 1'b1, 32'h40800000);
        waitDone("post_rst", st);
        checkOutput("post_rst_status", 32'(st), 32'h02);
        checkResult("post_rst_result");

`ifdef FPU_BUS_IRQ_EN
        // Interrupt: ien+GO, then CLR
        busWrite(4'h9, 8'h02);
        mock_delay = 4; mock_result = 32'h7FC00000;
        applyStimulus(32'h7FC00000, 32'h402df854, OP_ADD, 8'h05, 1'b1, 32'h7FC00000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!fpu_start) break;
        end
        checkOutput("irq_in_done", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("irq_after_done", 32'(irq), 32'h1);
        busRead(4'hA, st);
        checkOutput("irq_status", 32'(st), 32'h12);
        checkOutput("irq_held", 32'(irq), 32'h1);
        busWrite(4'h9, 8'h02);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        busRead(4'hA, st);
        checkOutput("irq_status_cleared", 32'(st), 32'h00);
        checkResult("irq_result");
`else
        checkOutput("irq_tied_low", 32'(irq), 32'h0);
`endif

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
